// File: rtl/dmem_pkg.sv
// dmem_pkg
//   Shared types and constants for the data-memory responder.
//   - state_e          : responder FSM states
//   - DEF_DEPTH_WORDS  : default number of 32-bit words
//   - DEF_WAIT_CYCLES  : default wait states between accept and response
//   - CNT_W            : width of the wait-state counter (covers 0..15)
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int DEF_DEPTH_WORDS = 256;
  localparam int DEF_WAIT_CYCLES = 2;
  localparam int CNT_W           = 4;

endpackage

// File: rtl/dmem_array.sv
// dmem_array
//   Word storage for dmem_responder: one synchronous write port, one
//   registered read port, asynchronous clear of every word and of the read
//   register.
//   Ports:
//     clk     : clock
//     rst_n   : asynchronous active-low clear
//     wr_en   : write wdata into mem[idx] on this edge
//     rd_en   : load mem[idx] into the read register on this edge
//     rd_clr  : force the read register to 0 on this edge (wins over rd_en)
//     idx     : word index shared by both ports
//     wdata   : write data
//     rdata   : registered read data
module dmem_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic             rd_clr,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      if (wr_en) begin
        mem_q[idx] <= wdata;
      end
      if (rd_clr) begin
        rdata_q <= '0;
      end else if (rd_en) begin
        rdata_q <= mem_q[idx];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
//   Memory-side responder for the core's data port. Accepts one request at
//   a time, waits WAIT_CYCLES states, performs the access on the edge that
//   enters RESP and holds the response until the core takes it.
//   Optional feature macro: DMEM_ERR_CHECK_EN (misaligned / out-of-range
//   requests complete with rsp_err=1, no store, rsp_rdata=0).
//   Ports:
//     CLK, RESET          : clock, asynchronous active-low reset
//     req_valid/req_ready : request handshake
//     req_write           : 1 = store, 0 = load
//     req_addr, req_wdata : byte address, store data
//     rsp_valid/rsp_ready : response handshake
//     rsp_rdata           : load data (0 for stores and errored requests)
//     rsp_err             : access error, valid with rsp_valid
//     busy                : high whenever the FSM is not IDLE
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cap_write_q, cap_write_d;
  logic               cap_err_q, cap_err_d;
  logic [IDX_W-1:0]   cap_idx_q, cap_idx_d;
  logic [31:0]        cap_wdata_q, cap_wdata_d;
  logic               rsp_err_q, rsp_err_d;
  logic               req_ready_q, req_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               busy_q, busy_d;

  logic               req_err;
  logic               access;
  logic               acc_write, acc_err;
  logic [IDX_W-1:0]   acc_idx;
  logic [31:0]        acc_wdata;

`ifdef DMEM_ERR_CHECK_EN
  assign req_err = (req_addr[1:0] != 2'b00) ||
                   (req_addr >= 32'(DEPTH_WORDS * 4));
`else
  // Addresses wrap: only the index bits are used.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[31:IDX_W+2], req_addr[1:0]};
  assign req_err          = 1'b0;
`endif

  // With zero wait states the access happens on the accept edge itself, so
  // it must use the live request rather than the not-yet-captured copy.
  always_comb begin
    if (state_q == IDLE) begin
      acc_write = req_write;
      acc_err   = req_err;
      acc_idx   = req_addr[IDX_W+1:2];
      acc_wdata = req_wdata;
    end else begin
      acc_write = cap_write_q;
      acc_err   = cap_err_q;
      acc_idx   = cap_idx_q;
      acc_wdata = cap_wdata_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cap_write_d = cap_write_q;
    cap_err_d   = cap_err_q;
    cap_idx_d   = cap_idx_q;
    cap_wdata_d = cap_wdata_q;
    rsp_err_d   = rsp_err_q;
    access      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          cap_write_d = req_write;
          cap_err_d   = req_err;
          cap_idx_d   = req_addr[IDX_W+1:2];
          cap_wdata_d = req_wdata;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            access  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          access  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d   = IDLE;
          rsp_err_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (access) begin
      rsp_err_d = acc_err;
    end
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cap_write_q <= 1'b0;
      cap_err_q   <= 1'b0;
      cap_idx_q   <= '0;
      cap_wdata_q <= '0;
      rsp_err_q   <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cap_write_q <= cap_write_d;
      cap_err_q   <= cap_err_d;
      cap_idx_q   <= cap_idx_d;
      cap_wdata_q <= cap_wdata_d;
      rsp_err_q   <= rsp_err_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Stores and errored requests return 0; errored stores never write.
  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk   (CLK),
    .rst_n (RESET),
    .wr_en (access && acc_write && !acc_err),
    .rd_en (access),
    .rd_clr(access && (acc_write || acc_err)),
    .idx   (acc_idx),
    .wdata (acc_wdata),
    .rdata (rsp_rdata)
  );

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign busy      = busy_q;
`ifdef DMEM_ERR_CHECK_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
//   Directed bench for dmem_responder. Instance 0 uses WAIT_CYCLES=2,
//   instance 1 uses WAIT_CYCLES=0; both share clock and reset. Latency is
//   counted as posedges from the accept edge (inclusive) until rsp_valid is
//   seen high, i.e. WAIT_CYCLES+1. Expected values under DMEM_ERR_CHECK_EN
//   follow the same macro.
module tb_dmem_responder;

`ifdef DMEM_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [1:0]  req_valid = '0, req_write = '0, req_ready, rsp_valid;
  logic [1:0]  rsp_ready = '0, rsp_err, busy;
  logic [31:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic [31:0] rsp_rdata [2];

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u_dut0 (
    .CLK(CLK), .RESET(RESET),
    .req_valid(req_valid[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_ready(req_ready[0]), .rsp_valid(rsp_valid[0]),
    .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .busy(busy[0])
  );

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_dut1 (
    .CLK(CLK), .RESET(RESET),
    .req_valid(req_valid[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_ready(req_ready[1]), .rsp_valid(rsp_valid[1]),
    .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .busy(busy[1])
  );

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One full transaction on instance d; returns data, error and latency.
  task automatic xact(input int d, input logic w, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd,
                      output logic er, output int lat);
    int guard;
    @(negedge CLK);
    req_valid[d] = 1'b1;
    req_write[d] = w;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    guard = 0;
    while (!req_ready[d] && guard < 20) begin
      @(negedge CLK);
      guard++;
    end
    @(posedge CLK);
    lat = 1;
    @(negedge CLK);
    req_valid[d] = 1'b0;
    while (!rsp_valid[d] && lat < 40) begin
      @(posedge CLK);
      lat++;
      @(negedge CLK);
    end
    rd = rsp_rdata[d];
    er = rsp_err[d];
    rsp_ready[d] = 1'b1;
    @(negedge CLK);
    rsp_ready[d] = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          guard;

    req_addr[0] = '0; req_addr[1] = '0;
    req_wdata[0] = '0; req_wdata[1] = '0;

    // Reset state
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    check_val("rst_req_ready", 32'(req_ready[0]), 32'd1);
    check_val("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    check_val("rst_rsp_rdata", rsp_rdata[0], 32'd0);
    check_val("rst_rsp_err",   32'(rsp_err[0]), 32'd0);
    check_val("rst_busy",      32'(busy[0]), 32'd0);

    // Store then load, WAIT_CYCLES=2
    xact(0, 1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat);
    check_val("st10_lat",   32'(lat), 32'd3);
    check_val("st10_rdata", rd, 32'd0);
    check_val("st10_err",   32'(er), 32'd0);
    xact(0, 1'b0, 32'h10, 32'h0, rd, er, lat);
    check_val("ld10_lat",   32'(lat), 32'd3);
    check_val("ld10_rdata", rd, 32'hDEADBEEF);

    // WAIT_CYCLES=0: load of cleared word, then store/load same index
    xact(1, 1'b0, 32'h0, 32'h0, rd, er, lat);
    check_val("w0_ld0_lat",   32'(lat), 32'd1);
    check_val("w0_ld0_rdata", rd, 32'd0);
    xact(1, 1'b1, 32'h8, 32'h55, rd, er, lat);
    check_val("w0_st8_lat", 32'(lat), 32'd1);
    xact(1, 1'b0, 32'h8, 32'h0, rd, er, lat);
    check_val("w0_ld8_rdata", rd, 32'h55);

    // Backpressure: hold rsp_ready low in RESP, second request ignored
    @(negedge CLK);
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 32'h10;
    @(posedge CLK);
    @(negedge CLK);
    req_write[0] = 1'b1; req_wdata[0] = 32'h00000BAD;
    guard = 0;
    while (!rsp_valid[0] && guard < 20) begin
      @(negedge CLK);
      guard++;
    end
    for (int i = 0; i < 5; i++) begin
      check_val("hold_rsp_valid", 32'(rsp_valid[0]), 32'd1);
      check_val("hold_rsp_rdata", rsp_rdata[0], 32'hDEADBEEF);
      check_val("hold_req_ready", 32'(req_ready[0]), 32'd0);
      @(negedge CLK);
    end
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    @(negedge CLK);
    rsp_ready[0] = 1'b0;
    check_val("hold_idle_ready", 32'(req_ready[0]), 32'd1);
    check_val("hold_idle_busy",  32'(busy[0]), 32'd0);
    xact(0, 1'b0, 32'h10, 32'h0, rd, er, lat);
    check_val("hold_no_store", rd, 32'hDEADBEEF);

    // Out-of-range store: wraps by default, errors with the check enabled
    xact(0, 1'b1, 32'h400, 32'h1234, rd, er, lat);
    check_val("st400_err", 32'(er), ERR_EN ? 32'd1 : 32'd0);
    check_val("st400_lat", 32'(lat), 32'd3);
    check_val("st400_err_after", 32'(rsp_err[0]), 32'd0);
    xact(0, 1'b0, 32'h0, 32'h0, rd, er, lat);
    check_val("ld0_wrap", rd, ERR_EN ? 32'd0 : 32'h1234);

    // Misaligned load: index 4 by default, error with the check enabled
    xact(0, 1'b0, 32'h13, 32'h0, rd, er, lat);
    check_val("ld13_err",   32'(er), ERR_EN ? 32'd1 : 32'd0);
    check_val("ld13_rdata", rd, ERR_EN ? 32'd0 : 32'hDEADBEEF);
    check_val("ld13_lat",   32'(lat), 32'd3);

    // Reset during WAIT of a store aborts it and clears storage
    xact(0, 1'b0, 32'h10, 32'h0, rd, er, lat);
    check_val("pre_rst_ld10", rd, 32'hDEADBEEF);
    @(negedge CLK);
    req_valid[0] = 1'b1; req_write[0] = 1'b1;
    req_addr[0] = 32'h20; req_wdata[0] = 32'hA5A5A5A5;
    @(posedge CLK);
    @(negedge CLK);
    req_valid[0] = 1'b0;
    check_val("pre_rst_busy", 32'(busy[0]), 32'd1);
    RESET = 1'b0;
    #1;
    check_val("mid_rst_req_ready", 32'(req_ready[0]), 32'd1);
    check_val("mid_rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    check_val("mid_rst_rsp_rdata", rsp_rdata[0], 32'd0);
    check_val("mid_rst_busy",      32'(busy[0]), 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    xact(0, 1'b0, 32'h20, 32'h0, rd, er, lat);
    check_val("post_rst_ld20", rd, 32'd0);
    xact(0, 1'b0, 32'h10, 32'h0, rd, er, lat);
    check_val("post_rst_ld10", rd, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
